// File: rtl/delay_prog_multi_if.sv
// ---------------------------------------------------------------------------
// delay_prog_multi_if
//   Channel bundle of the programmable multi-channel edge-delay cell.
//
//   Signal semantics (level based, no valid/ready handshake): every input is
//   sampled on each rising clock edge, and every output is a registered level
//   that is valid for the whole following clock cycle.
//
//   en     : 1 = delay active, 0 = bypass (outputs follow synchronised inputs)
//   i      : raw channel inputs (may be asynchronous when synchroniser is on)
//   dly    : delay code in clock cycles, shared by all channels
//   clr    : synchronous clear of the sticky glitch flags
//   o      : delayed channel outputs
//   busy   : channel is counting a pending edge
//   glitch : sticky flag, a pulse shorter than the delay was filtered
//   state  : FSM state per channel (1 = COUNT, 0 = IDLE), debug visibility
// ---------------------------------------------------------------------------
interface delay_prog_multi_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    logic           en;
    logic [NCH-1:0] i;
    logic [DW-1:0]  dly;
    logic           clr;
    logic [NCH-1:0] o;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] glitch;
    logic [NCH-1:0] state;

    modport master (
        output en, i, dly, clr,
        input  o, busy, glitch, state
    );

    modport slave (
        input  en, i, dly, clr,
        output o, busy, glitch, state
    );
endinterface

// File: rtl/delay_prog_multi.sv
// ---------------------------------------------------------------------------
// delay_prog_multi
//   NCH independent inertial edge-delay channels. Each selected edge on a
//   (optionally synchronised) input is held back by a programmable number of
//   clock cycles; if the input returns before the delay expires the pulse is
//   swallowed and a sticky glitch flag is raised for that channel.
//
// Ports:
//   CELCLK  : clock, rising edge
//   CELRST  : asynchronous active-high reset
//   CELV    : supply pin, no logic function
//   CELG    : ground pin, no logic function
//   CELSUB  : substrate pin, no logic function
//   bus     : channel bundle (en, i, dly, clr in; o, busy, glitch, state out)
//
// Parameters:
//   NCH     : number of channels
//   DW      : width of the delay code
//   EDGE    : 0 = delay rising only, 1 = falling only, 2 = both
//   SYNC    : input synchroniser depth, 0 or 2
//   RST_VAL : reset level of synchroniser flops and outputs
// ---------------------------------------------------------------------------
module delay_prog_multi #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int EDGE    = 2,
    parameter int SYNC    = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic               CELCLK,
    input  logic               CELRST,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               CELSUB,
    delay_prog_multi_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    // Power pins exist only for netlist compatibility.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ CELSUB;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [NCH-1:0] s;

    if (SYNC == 2) begin : g_sync
        logic [NCH-1:0] ff1;
        logic [NCH-1:0] ff2;
        always_ff @(posedge CELCLK or posedge CELRST) begin
            if (CELRST) begin
                ff1 <= {NCH{RST_VAL}};
                ff2 <= {NCH{RST_VAL}};
            end else begin
                ff1 <= bus.i;
                ff2 <= ff1;
            end
        end
        assign s = ff2;
    end else begin : g_nosync
        assign s = bus.i;
    end

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [DW-1:0]  cnt_q   [NCH];
    logic [DW-1:0]  cnt_d   [NCH];
    logic [DW-1:0]  dly_l_q [NCH];
    logic [DW-1:0]  dly_l_d [NCH];
    logic [NCH-1:0] o_q, o_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] glitch_q, glitch_d;
    logic [NCH-1:0] edge_dly;

    // Whether the pending edge (s differs from o) is one that gets delayed.
    // Only meaningful while s != o; non-selected edges pass straight through.
    always_comb begin
        edge_dly = '1;
        case (EDGE)
            0:       edge_dly = s & ~o_q;
            1:       edge_dly = ~s & o_q;
            default: edge_dly = '1;
        endcase
    end

    always_comb begin
        o_d    = o_q;
        busy_d = busy_q;
        // Clear first; a glitch set below overrides it in the same cycle.
        glitch_d = bus.clr ? '0 : glitch_q;
        for (int n = 0; n < NCH; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            dly_l_d[n] = dly_l_q[n];
            case (state_q[n])
                IDLE: begin
                    if (s[n] != o_q[n]) begin
                        if (edge_dly[n] && bus.en && (bus.dly != '0)) begin
                            dly_l_d[n] = bus.dly;
                            cnt_d[n]   = DW'(1);
                            state_d[n] = COUNT;
                            busy_d[n]  = 1'b1;
                        end else begin
                            o_d[n] = s[n];
                        end
                    end
                end
                COUNT: begin
                    if (!bus.en) begin
                        // Bypass requested: release the edge now, no flag.
                        o_d[n]     = s[n];
                        state_d[n] = IDLE;
                        busy_d[n]  = 1'b0;
                    end else if (s[n] == o_q[n]) begin
                        // Input returned before expiry: pulse is filtered.
                        state_d[n]  = IDLE;
                        busy_d[n]   = 1'b0;
                        glitch_d[n] = 1'b1;
                    end else if (cnt_q[n] == dly_l_q[n]) begin
                        o_d[n]     = s[n];
                        state_d[n] = IDLE;
                        busy_d[n]  = 1'b0;
                    end else begin
                        // Stops at dly_l, so never wraps.
                        cnt_d[n] = cnt_q[n] + 1'b1;
                    end
                end
                default: state_d[n] = IDLE;
            endcase
        end
    end

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            o_q      <= {NCH{RST_VAL}};
            busy_q   <= '0;
            glitch_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                state_q[n] <= IDLE;
                cnt_q[n]   <= '0;
                dly_l_q[n] <= '0;
            end
        end else begin
            o_q      <= o_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
            for (int n = 0; n < NCH; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                dly_l_q[n] <= dly_l_d[n];
            end
        end
    end

    always_comb begin
        bus.state = '0;
        for (int n = 0; n < NCH; n++) begin
            bus.state[n] = (state_q[n] == COUNT);
        end
    end

    assign bus.o      = o_q;
    assign bus.busy   = busy_q;
    assign bus.glitch = glitch_q;

endmodule

// File: tb/tb_delay_prog_multi.sv
// ---------------------------------------------------------------------------
// tb_delay_prog_multi
//   Directed bench for delay_prog_multi. Two instances share the same
//   stimulus: dut (EDGE=2, both edges delayed) and dut_e0 (EDGE=0, rising
//   edges only). Both use SYNC=2, so an input change first sampled at edge E0
//   reaches the output at E0+2 (undelayed) or E0+2+dly (delayed).
// ---------------------------------------------------------------------------
module tb_delay_prog_multi;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk;
    logic rst;
    logic cel_v;
    logic cel_g;
    logic cel_sub;

    int tests;
    int fails;

    delay_prog_multi_if #(.NCH(NCH), .DW(DW)) bus ();
    delay_prog_multi_if #(.NCH(NCH), .DW(DW)) bus0 ();

    delay_prog_multi #(
        .NCH(NCH), .DW(DW), .EDGE(2), .SYNC(2), .RST_VAL(1'b0)
    ) dut (
        .CELCLK (clk),
        .CELRST (rst),
        .CELV   (cel_v),
        .CELG   (cel_g),
        .CELSUB (cel_sub),
        .bus    (bus)
    );

    delay_prog_multi #(
        .NCH(NCH), .DW(DW), .EDGE(0), .SYNC(2), .RST_VAL(1'b0)
    ) dut_e0 (
        .CELCLK (clk),
        .CELRST (rst),
        .CELV   (cel_v),
        .CELG   (cel_g),
        .CELSUB (cel_sub),
        .bus    (bus0)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [NCH-1:0] iv,
                         input logic [DW-1:0] d, input logic c);
        bus.en   = en;  bus0.en  = en;
        bus.i    = iv;  bus0.i   = iv;
        bus.dly  = d;   bus0.dly = d;
        bus.clr  = c;   bus0.clr = c;
    endtask

    // Advance n rising edges, then sit 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'b0000, 8'd0, 1'b0);
        step(3);
        tests++;
        if (bus.o !== 4'b0000) begin
            fails++; $display("FAIL reset_o got %b want 0000", bus.o);
        end
        tests++;
        if (bus.busy !== 4'b0000 || bus.glitch !== 4'b0000 || bus.state !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got busy=%b glitch=%b state=%b want 0000",
                     bus.busy, bus.glitch, bus.state);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_delay_both();
        drive(1'b1, 4'b0000, 8'd5, 1'b0);
        step(2);
        drive(1'b1, 4'b0001, 8'd5, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            step(1);
            tests++;
            if (bus.o[0] !== 1'(k >= 7)) begin
                fails++; $display("FAIL both_rise_o k=%0d got %b want %b", k, bus.o[0], 1'(k >= 7));
            end
            tests++;
            if (bus.busy[0] !== 1'(k >= 2 && k <= 6)) begin
                fails++; $display("FAIL both_rise_busy k=%0d got %b want %b",
                                  k, bus.busy[0], 1'(k >= 2 && k <= 6));
            end
            if (k == 3) begin
                tests++;
                if (bus.state[0] !== 1'b1) begin
                    fails++; $display("FAIL both_state k=3 got %b want 1", bus.state[0]);
                end
            end
        end
        tests++;
        if (bus.glitch !== 4'b0000) begin
            fails++; $display("FAIL both_glitch got %b want 0000", bus.glitch);
        end
        // Falling edge is delayed too on this instance.
        drive(1'b1, 4'b0000, 8'd5, 1'b0);
        step(7);
        tests++;
        if (bus.o[0] !== 1'b1) begin
            fails++; $display("FAIL both_fall_early got %b want 1", bus.o[0]);
        end
        step(5);
        tests++;
        if (bus.o !== 4'b0000) begin
            fails++; $display("FAIL both_fall_done got %b want 0000", bus.o);
        end
    endtask

    task automatic test_edge_sel();
        drive(1'b1, 4'b0010, 8'd3, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            step(1);
            tests++;
            if (bus0.o[1] !== 1'(k >= 5)) begin
                fails++; $display("FAIL e0_rise k=%0d got %b want %b", k, bus0.o[1], 1'(k >= 5));
            end
        end
        drive(1'b1, 4'b0000, 8'd3, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            step(1);
            tests++;
            if (bus0.o[1] !== 1'(k < 2)) begin
                fails++; $display("FAIL e0_fall k=%0d got %b want %b", k, bus0.o[1], 1'(k < 2));
            end
            tests++;
            if (bus.o[1] !== 1'b1) begin
                fails++; $display("FAIL e2_fall_held k=%0d got %b want 1", k, bus.o[1]);
            end
        end
        step(6);
        tests++;
        if (bus.o[1] !== 1'b0) begin
            fails++; $display("FAIL e2_fall_done got %b want 0", bus.o[1]);
        end
    endtask

    task automatic test_glitch();
        drive(1'b1, 4'b0100, 8'd10, 1'b0);
        step(4);
        tests++;
        if (bus.busy[2] !== 1'b1) begin
            fails++; $display("FAIL glitch_busy got %b want 1", bus.busy[2]);
        end
        drive(1'b1, 4'b0000, 8'd10, 1'b0);
        step(4);
        tests++;
        if (bus.o[2] !== 1'b0 || bus.busy[2] !== 1'b0) begin
            fails++; $display("FAIL glitch_filtered got o=%b busy=%b want 0 0", bus.o[2], bus.busy[2]);
        end
        tests++;
        if (bus.glitch !== 4'b0100 || bus0.glitch !== 4'b0100) begin
            fails++; $display("FAIL glitch_flag got %b/%b want 0100", bus.glitch, bus0.glitch);
        end
        // clr alone clears
        drive(1'b1, 4'b0000, 8'd10, 1'b1);
        step(1);
        drive(1'b1, 4'b0000, 8'd10, 1'b0);
        tests++;
        if (bus.glitch !== 4'b0000) begin
            fails++; $display("FAIL glitch_clr1 got %b want 0000", bus.glitch);
        end
        // clr coincident with a new glitch: set wins
        drive(1'b1, 4'b0100, 8'd10, 1'b0);
        step(4);
        drive(1'b1, 4'b0000, 8'd10, 1'b0);
        step(2);
        drive(1'b1, 4'b0000, 8'd10, 1'b1);
        step(1);
        drive(1'b1, 4'b0000, 8'd10, 1'b0);
        tests++;
        if (bus.glitch[2] !== 1'b1) begin
            fails++; $display("FAIL glitch_set_wins got %b want 1", bus.glitch[2]);
        end
        step(2);
        tests++;
        if (bus.glitch[2] !== 1'b1) begin
            fails++; $display("FAIL glitch_sticky got %b want 1", bus.glitch[2]);
        end
        drive(1'b1, 4'b0000, 8'd10, 1'b1);
        step(1);
        drive(1'b1, 4'b0000, 8'd10, 1'b0);
        tests++;
        if (bus.glitch !== 4'b0000) begin
            fails++; $display("FAIL glitch_clr2 got %b want 0000", bus.glitch);
        end
    endtask

    task automatic test_dly_change();
        drive(1'b1, 4'b1000, 8'd8, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            step(1);
            if (k == 4) drive(1'b1, 4'b1000, 8'd2, 1'b0);
            tests++;
            if (bus.o[3] !== 1'(k >= 10)) begin
                fails++; $display("FAIL dlychg_rise k=%0d got %b want %b", k, bus.o[3], 1'(k >= 10));
            end
        end
        drive(1'b1, 4'b0000, 8'd2, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            step(1);
            tests++;
            if (bus.o[3] !== 1'(k < 4)) begin
                fails++; $display("FAIL dlychg_new k=%0d got %b want %b", k, bus.o[3], 1'(k < 4));
            end
        end
        step(2);
    endtask

    task automatic test_bypass();
        drive(1'b1, 4'b0001, 8'd0, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            step(1);
            tests++;
            if (bus.o[0] !== 1'(k >= 2) || bus.busy[0] !== 1'b0) begin
                fails++; $display("FAIL byp_dly0 k=%0d got o=%b busy=%b want %b 0",
                                  k, bus.o[0], bus.busy[0], 1'(k >= 2));
            end
        end
        drive(1'b0, 4'b0000, 8'd5, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            step(1);
            tests++;
            if (bus.o[0] !== 1'(k < 2)) begin
                fails++; $display("FAIL byp_en0 k=%0d got %b want %b", k, bus.o[0], 1'(k < 2));
            end
        end
        drive(1'b1, 4'b0001, 8'd10, 1'b0);
        step(5);
        tests++;
        if (bus.busy[0] !== 1'b1 || bus.o[0] !== 1'b0) begin
            fails++; $display("FAIL byp_midcount got busy=%b o=%b want 1 0", bus.busy[0], bus.o[0]);
        end
        drive(1'b0, 4'b0001, 8'd10, 1'b0);
        step(1);
        tests++;
        if (bus.o[0] !== 1'b1 || bus.busy[0] !== 1'b0 || bus.glitch !== 4'b0000) begin
            fails++; $display("FAIL byp_en_drop got o=%b busy=%b glitch=%b want 1 0 0000",
                              bus.o[0], bus.busy[0], bus.glitch);
        end
        drive(1'b1, 4'b0001, 8'd10, 1'b0);
        step(3);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 4'b0000, 8'd20, 1'b0);
        step(4);
        drive(1'b1, 4'b1111, 8'd20, 1'b0);
        step(5);
        tests++;
        if (bus.busy !== 4'b1111) begin
            fails++; $display("FAIL rstmid_busy got %b want 1111", bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.o !== 4'b0000 || bus.busy !== 4'b0000 || bus.glitch !== 4'b0000) begin
            fails++; $display("FAIL rstmid_async got o=%b busy=%b glitch=%b want 0000",
                              bus.o, bus.busy, bus.glitch);
        end
        drive(1'b1, 4'b0000, 8'd3, 1'b0);
        #2;
        rst = 1'b0;
        step(10);
        tests++;
        if (bus.busy !== 4'b0000 || bus.o !== 4'b0000) begin
            fails++; $display("FAIL rstmid_quiet got busy=%b o=%b want 0000", bus.busy, bus.o);
        end
        drive(1'b1, 4'b0001, 8'd3, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            step(1);
            tests++;
            if (bus.o[0] !== 1'(k >= 5)) begin
                fails++; $display("FAIL rstmid_restart k=%0d got %b want %b", k, bus.o[0], 1'(k >= 5));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        tests   = 0;
        fails   = 0;
        cel_v   = 1'b1;
        cel_g   = 1'b0;
        cel_sub = 1'b0;
        rst     = 1'b1;
        test_reset();
        test_delay_both();
        test_edge_sel();
        test_glitch();
        test_dly_change();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
